// File: rtl/rx_byte_fifo.sv
// rx_byte_fifo: single-clock byte FIFO feeding the APB read glue with registered read data
//
// Ports:
//   RdClk      - FIFO clock for both write and read sides
//   PRESETn    - asynchronous active-low reset; discards all stored data
//   WrEn       - producer write strobe
//   WrData     - producer byte
//   Full       - FIFO holds DEPTH entries
//   AlmostFull - occupancy >= AFULL_THRESH
//   RdEn       - consumer read strobe
//   RdData     - registered read byte, valid the cycle after an accepted read
//   Empty      - FIFO holds no entries
//   Count      - current occupancy, 0..DEPTH
//   Overflow   - sticky: write attempted while Full
//   Underflow  - sticky: read attempted while Empty
//   ClrErr     - synchronous clear of Overflow/Underflow (a same-cycle new error wins)
module rx_byte_fifo #(
   parameter int DEPTH        = 16,
   parameter int ADDR_W       = 4,
   parameter int AFULL_THRESH = 12
) (
   input  logic              RdClk,
   input  logic              PRESETn,
   input  logic              WrEn,
   input  logic [7:0]        WrData,
   output logic              Full,
   output logic              AlmostFull,
   input  logic              RdEn,
   output logic [7:0]        RdData,
   output logic              Empty,
   output logic [ADDR_W:0]   Count,
   output logic              Overflow,
   output logic              Underflow,
   input  logic              ClrErr
);
   localparam int CW = ADDR_W + 1;
   logic [7:0]    mem [DEPTH];
   logic [CW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
   logic [7:0]    rdata_q, rdata_d;
   logic          full_q, full_d, empty_q, empty_d, afull_q, afull_d;
   logic          ovf_q, ovf_d, udf_q, udf_d;
   logic          wr_acc, rd_acc;
   // acceptance uses the registered (pre-edge) flags, so an empty FIFO never falls through
   assign wr_acc = WrEn & ~full_q;
   assign rd_acc = RdEn & ~empty_q;
   always_comb begin
      wr_ptr_d = wr_acc ? wr_ptr_q + CW'(1) : wr_ptr_q;
      rd_ptr_d = rd_acc ? rd_ptr_q + CW'(1) : rd_ptr_q;
      rdata_d  = rd_acc ? mem[rd_ptr_q[ADDR_W-1:0]] : rdata_q;
      count_d  = (wr_acc & ~rd_acc) ? count_q + CW'(1) :
                 (rd_acc & ~wr_acc) ? count_q - CW'(1) : count_q;
      full_d   = (count_d == CW'(DEPTH));
      empty_d  = (count_d == '0);
      afull_d  = (count_d >= CW'(AFULL_THRESH));
      ovf_d    = (WrEn & full_q) | (ovf_q & ~ClrErr);
      udf_d    = (RdEn & empty_q) | (udf_q & ~ClrErr);
   end
   always_ff @(posedge RdClk or negedge PRESETn) begin
      if (!PRESETn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         rdata_q  <= 8'h00;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         afull_q  <= 1'b0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         rdata_q  <= rdata_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
         afull_q  <= afull_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end
   // storage is deliberately not reset; the pointers make stale contents unreachable
   always_ff @(posedge RdClk) begin
      if (wr_acc) mem[wr_ptr_q[ADDR_W-1:0]] <= WrData;
   end
   assign Full       = full_q;
   assign Empty      = empty_q;
   assign AlmostFull = afull_q;
   assign Count      = count_q;
   assign RdData     = rdata_q;
   assign Overflow   = ovf_q;
   assign Underflow  = udf_q;
endmodule

// File: tb/tb_rx_byte_fifo.sv
// tb_rx_byte_fifo: directed self-checking bench for rx_byte_fifo
module tb_rx_byte_fifo;
   logic       RdClk = 1'b0, PRESETn = 1'b0, WrEn = 1'b0, RdEn = 1'b0, ClrErr = 1'b0;
   logic [7:0] WrData = 8'h00, RdData;
   logic       Full, AlmostFull, Empty, Overflow, Underflow;
   logic [4:0] Count;
   int         checks = 0, failures = 0;

   rx_byte_fifo #(.DEPTH(16), .ADDR_W(4), .AFULL_THRESH(12)) dut (
      .RdClk(RdClk), .PRESETn(PRESETn), .WrEn(WrEn), .WrData(WrData),
      .Full(Full), .AlmostFull(AlmostFull), .RdEn(RdEn), .RdData(RdData),
      .Empty(Empty), .Count(Count), .Overflow(Overflow), .Underflow(Underflow),
      .ClrErr(ClrErr)
   );

   always #5 RdClk = ~RdClk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic w, input logic [7:0] wd, input logic r, input logic c);
      @(negedge RdClk);
      WrEn = w; WrData = wd; RdEn = r; ClrErr = c;
      @(posedge RdClk);
      #1;
   endtask

   function automatic logic [7:0] pat(input int i);
      return 8'(i * 7 + 3);
   endfunction

   initial begin
      #12;
      chk("rst_empty", Empty, 1);
      chk("rst_full", Full, 0);
      chk("rst_count", Count, 0);
      chk("rst_rdata", RdData, 8'h00);
      chk("rst_afull", AlmostFull, 0);
      chk("rst_ovf", Overflow, 0);
      chk("rst_udf", Underflow, 0);
      @(negedge RdClk);
      PRESETn = 1'b1;

      for (int i = 0; i < 4; i++) begin
         cyc(1, 8'hA1 + 8'(i), 0, 0);
         chk("wr4_count", Count, 32'(i + 1));
      end
      chk("wr4_empty", Empty, 0);
      for (int i = 0; i < 4; i++) begin
         cyc(0, 8'h00, 1, 0);
         chk("rd4_data", RdData, 8'hA1 + 8'(i));
         chk("rd4_count", Count, 32'(3 - i));
      end
      chk("rd4_empty", Empty, 1);

      for (int i = 0; i < 16; i++) begin
         cyc(1, 8'(i), 0, 0);
         chk("fill_count", Count, 32'(i + 1));
         chk("fill_afull", AlmostFull, 32'(i + 1 >= 12));
         chk("fill_full", Full, 32'(i + 1 == 16));
      end
      cyc(1, 8'hFF, 0, 0);
      chk("ovf_set", Overflow, 1);
      chk("ovf_count", Count, 16);
      cyc(0, 8'h00, 0, 1);
      chk("ovf_clr", Overflow, 0);

      cyc(1, 8'hEE, 1, 0);
      chk("full_rw_data", RdData, 8'h00);
      chk("full_rw_count", Count, 15);
      chk("full_rw_ovf", Overflow, 1);
      chk("full_rw_full", Full, 0);
      cyc(0, 8'h00, 0, 1);
      chk("full_rw_clr", Overflow, 0);
      for (int i = 1; i < 16; i++) begin
         cyc(0, 8'h00, 1, 0);
         chk("drain_data", RdData, 32'(i));
      end
      chk("drain_empty", Empty, 1);
      chk("drain_count", Count, 0);

      cyc(1, 8'h5A, 1, 0);
      chk("udf_set", Underflow, 1);
      chk("udf_count", Count, 1);
      chk("udf_hold", RdData, 8'h0F);
      cyc(0, 8'h00, 1, 0);
      chk("udf_next", RdData, 8'h5A);
      chk("udf_next_cnt", Count, 0);
      cyc(0, 8'h00, 1, 1);
      chk("set_wins", Underflow, 1);
      cyc(0, 8'h00, 0, 1);
      chk("udf_clr", Underflow, 0);

      cyc(1, pat(0), 0, 0);
      for (int i = 1; i <= 40; i++) begin
         cyc(1, pat(i), 1, 0);
         chk("wrap_data", RdData, pat(i - 1));
         chk("wrap_count", Count, 1);
      end
      cyc(0, 8'h00, 1, 0);
      chk("wrap_last", RdData, pat(40));
      chk("wrap_empty", Empty, 1);

      for (int i = 0; i < 7; i++) cyc(1, 8'h30 + 8'(i), 0, 0);
      chk("pre_rst_count", Count, 7);
      cyc(0, 8'h00, 0, 0);
      @(negedge RdClk);
      #2 PRESETn = 1'b0;
      #1;
      chk("arst_empty", Empty, 1);
      chk("arst_count", Count, 0);
      chk("arst_rdata", RdData, 8'h00);
      @(negedge RdClk);
      PRESETn = 1'b1;
      cyc(1, 8'h11, 0, 0);
      cyc(1, 8'h22, 0, 0);
      chk("post_count", Count, 2);
      cyc(0, 8'h00, 1, 0);
      chk("post_rd1", RdData, 8'h11);
      cyc(0, 8'h00, 1, 0);
      chk("post_rd2", RdData, 8'h22);
      chk("post_empty", Empty, 1);
      cyc(0, 8'h00, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/rx_byte_fifo.md
Name: rx_byte_fifo

Overview:
Single-clock 8-bit byte FIFO that buffers bytes from the receive-side producer. Its read port feeds the APB read glue logic, which assembles four bytes into one 32-bit PRDATA word. The read port follows the glue's timing: RdEn is sampled on RdClk, and RdData is registered and valid on the following cycle. It also provides occupancy, almost-full, and sticky overflow/underflow status.

Parameters:
DEPTH, 16, number of byte entries; must be a power of two and at least 4.
ADDR_W, 4, log2(DEPTH); width of the storage index.
AFULL_THRESH, 12, Count value at or above which AlmostFull asserts; range 1..DEPTH.

Ports:
RdClk  input  1  FIFO clock. Drives both the write and read sides.
PRESETn  input  1  Reset, asynchronous, active-low.
WrEn  input  1  Producer write strobe, sampled on posedge RdClk.
WrData  input  8  Producer byte.
Full  output  1  FIFO holds DEPTH entries.
AlmostFull  output  1  Count >= AFULL_THRESH.
RdEn  input  1  Consumer read strobe from the glue logic, sampled on posedge RdClk.
RdData  output  8  Registered read byte.
Empty  output  1  FIFO holds 0 entries.
Count  output  ADDR_W+1  Current occupancy, 0..DEPTH.
Overflow  output  1  Sticky flag: a write was attempted while Full.
Underflow  output  1  Sticky flag: a read was attempted while Empty.
ClrErr  input  1  Synchronous clear of Overflow and Underflow.

Behaviour:
- Reset (PRESETn=0, asynchronous):
  - wr_ptr and rd_ptr (ADDR_W+1 bits each) = 0; Count = 0.
  - RdData = 8'h00; Empty = 1; Full = 0; AlmostFull = 0; Overflow = 0; Underflow = 0.
  - Storage contents are not reset.
- Reset mid-operation: all stored data is discarded immediately and the FIFO restarts empty. There is no partial-state recovery.
- Write acceptance: wr_acc = WrEn & ~Full, evaluated from the pre-edge Full.
  - On acceptance, mem[wr_ptr[ADDR_W-1:0]] <= WrData and wr_ptr increments.
- Read acceptance: rd_acc = RdEn & ~Empty, evaluated from the pre-edge Empty.
  - On acceptance, RdData <= mem[rd_ptr[ADDR_W-1:0]] and rd_ptr increments.
  - Read latency is one cycle. The byte is visible after the edge that sampled RdEn and stays stable until the next accepted read.
  - With no accepted read, RdData holds its last value.
- Simultaneous write and read:
  - Both accepted when not Full and not Empty; Count is unchanged.
  - When Empty: the write is accepted and the read is ignored (no fall-through). Underflow sets and Count becomes 1.
  - When Full: the read is accepted and the write is rejected. Overflow sets and Count becomes DEPTH-1.
- Count update: Count <= Count + wr_acc - rd_acc. Count never exceeds DEPTH and never goes below 0.
- Status outputs are registered and updated in the same cycle as the pointers:
  - Full = (Count == DEPTH); Empty = (Count == 0); AlmostFull = (Count >= AFULL_THRESH).
- Pointer wrap-around: pointers are ADDR_W+1 bits and wrap naturally at 2*DEPTH.
  - The index uses the low ADDR_W bits.
  - Full/Empty derived from the pointers must always agree with Count.
- Error flags:
  - Overflow sets on WrEn & Full; Underflow sets on RdEn & Empty.
  - ClrErr clears both flags. If a new error occurs in the same cycle as ClrErr, the set wins.
- Back-to-back reads: the consumer may hold RdEn high on consecutive cycles. Each cycle with ~Empty delivers the next byte.

Test Plan:
- Reset, then write A1,A2,A3,A4 on consecutive cycles, then hold RdEn for 4 cycles -> RdData sequence A1,A2,A3,A4, each one cycle after its RdEn edge. Count goes 4,3,2,1,0; Empty=1 after the last read.
- Write 16 bytes 00..0F -> AlmostFull asserts when Count=12 and Full asserts when Count=16. A 17th write (0xFF) sets Overflow, and contents still read back 00..0F.
- From empty, assert RdEn with WrEn=1, WrData=5A -> Underflow=1, Count=1, RdData stays unchanged. The next RdEn returns 5A.
- When Full, assert WrEn and RdEn together -> the oldest byte is read, the write is dropped, Count=15, Overflow=1. ClrErr on the next cycle -> Overflow=0.
- Run 40 interleaved write/read pairs -> pointer wrap verified: byte order preserved, Count stable at its steady level.
- Assert PRESETn low mid-stream with Count=7 -> Empty=1, Count=0, RdData=00 immediately (asynchronous). Subsequent writes and reads behave as after a fresh reset.
